// File: rtl/crc8_frame_arb.sv
// rtl/crc8_frame_arb.sv - two-requester frame arbiter feeding a bit-serial CRC-8 engine
//
// Purpose: grants one of two byte-stream requesters per frame (round-robin),
// clears the external CRC-8 engine at frame start, hands it one byte at a
// time, waits for its byte-complete pulse (with a timeout), and reports the
// final CRC of each frame on a one-cycle result strobe.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_sX_data/valid/last      byte stream from requester X (X = 0, 1)
//   o_sX_ready                byte accepted when valid & ready
//   o_eng_clr                 one-cycle engine clear at frame start
//   o_eng_enable              one-cycle engine start for o_eng_byte
//   o_eng_byte                byte under processing, held while waiting
//   i_eng_done, i_eng_crc     engine byte-complete pulse and running CRC
//   o_res_valid               one-cycle result strobe
//   o_res_chan/crc/err        reported frame channel, CRC, timeout abort

module crc8_frame_arb #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_s0_data,
  input  logic       i_s0_valid,
  input  logic       i_s0_last,
  output logic       o_s0_ready,
  input  logic [7:0] i_s1_data,
  input  logic       i_s1_valid,
  input  logic       i_s1_last,
  output logic       o_s1_ready,
  output logic       o_eng_clr,
  output logic       o_eng_enable,
  output logic [7:0] o_eng_byte,
  input  logic       i_eng_done,
  input  logic [7:0] i_eng_crc,
  output logic       o_res_valid,
  output logic       o_res_chan,
  output logic [7:0] o_res_crc,
  output logic       o_res_err
);

  // The counter is 0 in the eng_enable cycle; the edge that would take it to
  // TIMEOUT is the one that aborts, so the result lands TIMEOUT cycles after
  // eng_enable.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCEPT,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       r_grant;
  logic       r_last_grant;
  logic       r_last;
  logic [7:0] r_eng_byte;
  logic [7:0] r_crc_cap;
  logic [7:0] r_cnt;
  logic       r_res_chan;
  logic [7:0] r_res_crc;
  logic       r_res_err;

  logic       w_do_grant;
  logic       w_grant_ch;
  logic       w_accept;
  logic       w_done;
  logic       w_timeout;
  logic       w_sel_valid;
  logic       w_sel_last;
  logic [7:0] w_sel_data;

  assign w_sel_valid = r_grant ? i_s1_valid : i_s0_valid;
  assign w_sel_last  = r_grant ? i_s1_last  : i_s0_last;
  assign w_sel_data  = r_grant ? i_s1_data  : i_s0_data;

  // Tie goes to the channel that did not win last; r_last_grant resets to 1
  // so channel 0 wins the first tie.
  assign w_grant_ch  = (i_s0_valid && i_s1_valid) ? ~r_last_grant : i_s1_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_do_grant   = 1'b0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    o_s0_ready   = 1'b0;
    o_s1_ready   = 1'b0;
    o_eng_clr    = 1'b0;
    o_eng_enable = 1'b0;
    o_res_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_s0_valid || i_s1_valid) begin
          w_do_grant = 1'b1;
          w_next     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        o_eng_clr = 1'b1;
        w_next    = S_ACCEPT;
      end
      S_ACCEPT: begin
        o_s0_ready = ~r_grant;
        o_s1_ready = r_grant;
        if (w_sel_valid) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        o_eng_enable = (r_cnt == 8'd0);
        // A done arriving on the final counted cycle still wins over timeout.
        if (i_eng_done) begin
          w_done = 1'b1;
          w_next = r_last ? S_RESULT : S_ACCEPT;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_RESULT;
        end
      end
      S_RESULT: begin
        o_res_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_last       <= 1'b0;
      r_eng_byte   <= 8'd0;
      r_crc_cap    <= 8'd0;
      r_cnt        <= 8'd0;
      r_res_chan   <= 1'b0;
      r_res_crc    <= 8'd0;
      r_res_err    <= 1'b0;
    end else begin
      if (w_do_grant) begin
        r_grant      <= w_grant_ch;
        r_last_grant <= w_grant_ch;
      end

      // Per-frame capture: a frame that times out before any byte completes
      // reports 0 rather than a previous frame's CRC.
      if (r_state == S_CLEAR) begin
        r_crc_cap <= 8'd0;
      end else if (w_done) begin
        r_crc_cap <= i_eng_crc;
      end

      if (w_accept) begin
        r_eng_byte <= w_sel_data;
        r_last     <= w_sel_last;
        r_cnt      <= 8'd0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end

      // Result fields are loaded only on the way into RESULT and then hold.
      if ((w_done && r_last) || w_timeout) begin
        r_res_chan <= r_grant;
        r_res_crc  <= w_done ? i_eng_crc : r_crc_cap;
        r_res_err  <= w_timeout;
      end
    end
  end

  assign o_eng_byte = r_eng_byte;
  assign o_res_chan = r_res_chan;
  assign o_res_crc  = r_res_crc;
  assign o_res_err  = r_res_err;

endmodule
